// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: 10-bit word PC, single-cycle IF stage with IF/ID register.
// BOOT -> FETCH -> HALT state machine; jump/branch redirects cost one bubble.
// Optional fetch counter compiled in when FETCH_STATS_EN is defined.
module pc_fetch_unit #(
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [9:0]  jump_target,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic [31:0] instr_in,
    output logic [8:0]  address,
    output logic        signal,
    output logic [31:0] instr_out,
    output logic [9:0]  pc_out,
    output logic        valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    logic [9:0]  pc;
    logic        redirect;
    logic        is_halt_word;
    logic [9:0]  branch_target;
    logic [5:0]  unused_off_hi;
    logic [9:0]  next_pc;

    // Memory is addressed straight from the PC; forced to zero during reset
    assign address = reset ? '0 : pc[8:0];
    assign signal  = reset ? 1'b0 : pc[9];

    // Redirect decode and next-PC selection (jump > branch > sequential)
    always_comb begin
        {unused_off_hi, branch_target} = {6'd0, pc_out} + 16'd1 + branch_offset;
        redirect     = (state == FETCH) && valid && !stall && (jump || branch_taken);
        is_halt_word = (instr_in == HALT_WORD);
        next_pc      = pc + 10'd1;
        if (valid && jump) begin
            next_pc = jump_target;
        end else if (valid && branch_taken) begin
            next_pc = branch_target;
        end
    end

    // Fetch state machine with the IF/ID register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BOOT;
            pc        <= '0;
            instr_out <= '0;
            pc_out    <= '0;
            valid     <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (!stall) begin
                        instr_out <= instr_in;
                        pc_out    <= pc;
                        if (redirect) begin
                            // word fetched this edge is wrong-path: drop it
                            pc    <= next_pc;
                            valid <= 1'b0;
                        end else if (is_halt_word) begin
                            valid  <= 1'b0;
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            pc    <= next_pc;
                            valid <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic set_valid;

    assign set_valid = (state == FETCH) && !stall && !redirect && !is_halt_word;

    // Saturating count of edges that deliver a live instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (set_valid && (fetch_count != 16'hFFFF)) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: boot, sequential fetch, bank wrap,
// jump/branch bubbles, stall hold, redirect-over-halt, halt and reset.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        jump;
    logic [9:0]  jump_target;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic [31:0] instr_in;
    logic [8:0]  address;
    logic        signal;
    logic [31:0] instr_out;
    logic [9:0]  pc_out;
    logic        valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic        halt_force;
    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned exp_cnt = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.HALT_WORD(32'hFFFF_FFFF)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .instr_in     (instr_in),
        .address      (address),
        .signal       (signal),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .valid        (valid),
        .halted       (halted),
        .fetch_count  (fetch_count)
    );

    // Instruction memory model: word encodes its own address
    assign instr_in = halt_force ? 32'hFFFF_FFFF : {16'hC0DE, 6'd0, signal, address};

    function automatic logic [31:0] word(input logic [9:0] p);
        return {16'hC0DE, 6'd0, p};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic check_cnt(input string tag);
`ifdef FETCH_STATS_EN
        check(tag, {16'd0, fetch_count}, exp_cnt);
`else
        check(tag, {16'd0, fetch_count}, 32'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // check PC (address+signal), valid and counter in one go
    task automatic check_pc(input string tag, input logic [9:0] p, input logic v);
        check({tag, "_addr"}, {23'd0, address}, {23'd0, p[8:0]});
        check({tag, "_sig"}, {31'd0, signal}, {31'd0, p[9]});
        check({tag, "_valid"}, {31'd0, valid}, {31'd0, v});
        check_cnt({tag, "_cnt"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; jump = 1'b0; jump_target = '0;
        branch_taken = 1'b0; branch_offset = '0; halt_force = 1'b0;

        // Reset state
        step();
        check("rst_addr", {23'd0, address}, 32'd0);
        check("rst_sig", {31'd0, signal}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_pcout", {22'd0, pc_out}, 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check_cnt("rst_cnt");
        reset = 1'b0;
        stall = 1'b1;                    // ignored in BOOT

        // BOOT cycle: pc held, valid low
        step();
        check_pc("boot", 10'd0, 1'b0);
        stall = 1'b0;

        // Sequential fetch 0,1,2,3
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_cnt++;
            check_pc("seq", 10'(i), 1'b1);
            check("seq_pcout", {22'd0, pc_out}, 32'(i - 1));
            check("seq_instr", instr_out, word(10'(i - 1)));
        end

        // Jump to 510: one bubble
        jump = 1'b1; jump_target = 10'h1FE;
        step();
        jump = 1'b0;
        check_pc("jmp", 10'h1FE, 1'b0);
        step(); exp_cnt++;
        check_pc("p511", 10'h1FF, 1'b1);
        check("p511_instr", instr_out, word(10'h1FE));
        step(); exp_cnt++;
        check_pc("p512", 10'h200, 1'b1);

        // Jump to 1023 then wrap to 0
        jump = 1'b1; jump_target = 10'h3FF;
        step();
        jump = 1'b0;
        check_pc("j3ff", 10'h3FF, 1'b0);
        step(); exp_cnt++;
        check_pc("wrap", 10'h000, 1'b1);
        check("wrap_pcout", {22'd0, pc_out}, 32'h3FF);
        check("wrap_instr", instr_out, word(10'h3FF));

        // Advance until pc_out = 5
        for (int i = 1; i <= 6; i++) begin
            step(); exp_cnt++;
            check_pc("adv", 10'(i), 1'b1);
        end
        check("adv_pcout", {22'd0, pc_out}, 32'd5);

        // Branch -2 from pc_out=5 -> target 4
        branch_taken = 1'b1; branch_offset = 16'hFFFE;
        step();
        branch_taken = 1'b0;
        check_pc("br", 10'd4, 1'b0);
        // jump during bubble must be ignored
        jump = 1'b1; jump_target = 10'h3AA;
        step(); exp_cnt++;
        jump = 1'b0;
        check_pc("br_after", 10'd5, 1'b1);
        check("br_instr", instr_out, word(10'd4));

        // Stall for 3 cycles (redirect ignored while stalled)
        stall = 1'b1; jump = 1'b1; jump_target = 10'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            check_pc("stall", 10'd5, 1'b1);
            check("stall_instr", instr_out, word(10'd4));
        end
        stall = 1'b0; jump = 1'b0;
        step(); exp_cnt++;
        check_pc("resume", 10'd6, 1'b1);
        check("resume_instr", instr_out, word(10'd5));

        // Redirect beats halt word on the same edge
        halt_force = 1'b1; jump = 1'b1; jump_target = 10'd7;
        step();
        jump = 1'b0;
        check_pc("redir_halt", 10'd7, 1'b0);
        check("redir_halted", {31'd0, halted}, 32'd0);

        // Halt at pc=7 (valid=0, so no redirect possible)
        step();
        check_pc("halt", 10'd7, 1'b0);
        check("halt_halted", {31'd0, halted}, 32'd1);
        halt_force = 1'b0;
        for (int i = 0; i < 10; i++) begin
            jump = i[0]; stall = i[1]; branch_taken = i[2];
            step();
            check_pc("hold", 10'd7, 1'b0);
            check("hold_halted", {31'd0, halted}, 32'd1);
        end
        jump = 1'b0; stall = 1'b1; branch_taken = 1'b0;

        // Reset overrides halt and stall
        reset = 1'b1;
        step();
        exp_cnt = 0;
        check_pc("rst2", 10'd0, 1'b0);
        check("rst2_halted", {31'd0, halted}, 32'd0);
        reset = 1'b0; stall = 1'b0;
        step();
        check_pc("boot2", 10'd0, 1'b0);
        step(); exp_cnt++;
        check_pc("run2", 10'd1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
